// File: rtl/riscy_pkg.sv
// Shared constants for the RV32I control unit: opcodes, ALU/immediate/result encodings,
// flag bit positions and branch funct3 codes.
package riscy_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd8;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_U = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;

  // Instruction class handed from the main decoder to the ALU decoder.
  typedef enum logic [1:0] {
    ALUOP_ADD = 2'd0,
    ALUOP_SUB = 2'd1,
    ALUOP_R   = 2'd2,
    ALUOP_I   = 2'd3
  } aluop_e;

endpackage

// File: rtl/riscy_control_alu_decoder.sv
// ALU operation select from instruction class, funct3 and instruction[30].
module alu_decoder
  import riscy_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [2:0] funct3,
  input  logic       funct7,
  output logic [3:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_R:   alu_control = {funct7, funct3};
      // For immediates bit 30 is only an opcode bit for shift-right (srai vs srli).
      ALUOP_I:   alu_control = {(funct3 == 3'd5) & funct7, funct3};
      default:   alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/riscy_control.sv
// RV32I single-cycle control unit: combinational decode plus sticky illegal flag and
// an optional taken-branch counter enabled by RISCY_CONTROL_BRANCH_CNT_EN.
module riscy_control
  import riscy_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  op,
  input  logic [2:0]  funct3,
  input  logic        funct7,
  input  logic [3:0]  flags,
  output logic        RegWrite,
  output logic        ALUSrc,
  output logic        MemWrite,
  output logic        PCSrc,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  ResultSrc,
  output logic [3:0]  ALUControl,
  output logic        IllegalOp,
  output logic        IllegalSeen,
  output logic [31:0] BranchCount
);

  logic [1:0] aluop;
  logic       is_branch;
  logic       is_jal;
  logic       taken;

  always_comb begin
    RegWrite  = 1'b0;
    ALUSrc    = 1'b0;
    MemWrite  = 1'b0;
    ImmSrc    = IMM_I;
    ResultSrc = RES_ALU;
    aluop     = ALUOP_ADD;
    IllegalOp = 1'b0;
    is_branch = 1'b0;
    is_jal    = 1'b0;
    case (op)
      OP_R:      begin RegWrite = 1'b1; aluop = ALUOP_R; end
      OP_I:      begin RegWrite = 1'b1; ALUSrc = 1'b1; aluop = ALUOP_I; end
      OP_LOAD:   begin RegWrite = 1'b1; ALUSrc = 1'b1; ResultSrc = RES_MEM; end
      OP_STORE:  begin ALUSrc = 1'b1; MemWrite = 1'b1; ImmSrc = IMM_S; end
      // Branch keeps MemWrite/ImmSrc as the datapath expects them, oddities included.
      OP_BRANCH: begin
        ALUSrc = 1'b1; MemWrite = 1'b1; ImmSrc = IMM_S;
        aluop = ALUOP_SUB; is_branch = 1'b1;
      end
      OP_JAL:    begin RegWrite = 1'b1; ImmSrc = IMM_J; ResultSrc = RES_PC4; is_jal = 1'b1; end
      OP_LUI:    begin RegWrite = 1'b1; ImmSrc = IMM_U; end
      default:   IllegalOp = 1'b1;
    endcase
  end

  alu_decoder u_alu_decoder (
    .aluop       (aluop),
    .funct3      (funct3),
    .funct7      (funct7),
    .alu_control (ALUControl)
  );

  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3_BEQ:  taken = flags[FLAG_Z];
      F3_BNE:  taken = ~flags[FLAG_Z];
      F3_BLT:  taken = flags[FLAG_N] ^ flags[FLAG_V];
      F3_BGE:  taken = ~(flags[FLAG_N] ^ flags[FLAG_V]);
      F3_BLTU: taken = ~flags[FLAG_C];
      F3_BGEU: taken = flags[FLAG_C];
      default: taken = 1'b0;
    endcase
  end

  assign PCSrc = (is_branch & taken) | is_jal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) IllegalSeen <= 1'b0;
    else if (IllegalOp) IllegalSeen <= 1'b1;
  end

`ifdef RISCY_CONTROL_BRANCH_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) BranchCount <= 32'd0;
    else if (PCSrc) BranchCount <= BranchCount + 32'd1;
  end
`else
  assign BranchCount = 32'd0;
`endif

endmodule

// File: tb/tb_riscy_control.sv
// Bench for riscy_control: spec-level decode model feeding an expected queue, checked every
// cycle, plus hand-computed literal expectations for the listed scenarios.
module tb_riscy_control;

  logic        clk;
  logic        rst_n;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7;
  logic [3:0]  flags;
  logic        RegWrite, ALUSrc, MemWrite, PCSrc, IllegalOp, IllegalSeen;
  logic [1:0]  ImmSrc, ResultSrc;
  logic [3:0]  ALUControl;
  logic [31:0] BranchCount;

  riscy_control dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7(funct7), .flags(flags),
    .RegWrite(RegWrite), .ALUSrc(ALUSrc), .MemWrite(MemWrite), .PCSrc(PCSrc),
    .ImmSrc(ImmSrc), .ResultSrc(ResultSrc), .ALUControl(ALUControl),
    .IllegalOp(IllegalOp), .IllegalSeen(IllegalSeen), .BranchCount(BranchCount)
  );

  // Packed view: {RegWrite,ALUSrc,MemWrite,PCSrc,ImmSrc,ResultSrc,ALUControl,IllegalOp}
  logic [12:0] act;
  assign act = {RegWrite, ALUSrc, MemWrite, PCSrc, ImmSrc, ResultSrc, ALUControl, IllegalOp};

  int n_total = 0;
  int n_pass  = 0;
  logic [12:0] exp_q[$];
  logic        m_seen;
  logic [31:0] m_cnt;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [12:0] model(logic [6:0] o, logic [2:0] f3, logic f7, logic [3:0] fl);
    logic rw, as, mw, pc, ill, n, z, c, v;
    logic [1:0] imm, res;
    logic [3:0] alu;
    {rw, as, mw, pc, ill} = 5'b0;
    imm = 2'd0; res = 2'd0; alu = 4'd0;
    n = fl[3]; z = fl[2]; c = fl[1]; v = fl[0];
    if (o == 7'b0110011) begin rw = 1; alu = {f7, f3}; end
    else if (o == 7'b0010011) begin rw = 1; as = 1; alu = {(f3 == 3'd5) ? f7 : 1'b0, f3}; end
    else if (o == 7'b0000011) begin rw = 1; as = 1; res = 2'b01; end
    else if (o == 7'b0100011) begin as = 1; mw = 1; imm = 2'b01; end
    else if (o == 7'b1100011) begin
      as = 1; mw = 1; imm = 2'b01; alu = 4'd8;
      if (f3 == 0) pc = z;
      else if (f3 == 1) pc = !z;
      else if (f3 == 4) pc = (n != v);
      else if (f3 == 5) pc = (n == v);
      else if (f3 == 6) pc = !c;
      else if (f3 == 7) pc = c;
    end
    else if (o == 7'b1101111) begin rw = 1; imm = 2'b11; res = 2'b10; pc = 1; end
    else if (o == 7'b0110111) begin rw = 1; imm = 2'b10; end
    else ill = 1;
    return {rw, as, mw, pc, imm, res, alu, ill};
  endfunction

  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    n_total++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, a, e, $time);
  endtask

  // Status-register model driven by the same rules the datapath relies on.
  always @(posedge clk or negedge rst_n) begin
    logic [12:0] m;
    if (!rst_n) begin
      m_seen <= 1'b0;
      m_cnt  <= 32'd0;
    end else begin
      m = model(op, funct3, funct7, flags);
      if (m[0]) m_seen <= 1'b1;
`ifdef RISCY_CONTROL_BRANCH_CNT_EN
      if (m[9]) m_cnt <= m_cnt + 32'd1;
`endif
    end
  end

  // scoreboard: compare every cycle on the falling edge
  always @(negedge clk) begin
    logic [12:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("decode", {19'd0, act}, {19'd0, e});
    end
    chk("illegal_seen", {31'd0, IllegalSeen}, {31'd0, m_seen});
    chk("branch_count", BranchCount, m_cnt);
  end

  // driver
  task automatic apply(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic [3:0] fl);
    @(posedge clk);
    #1;
    op = o; funct3 = f3; funct7 = f7; flags = fl;
    exp_q.push_back(model(o, f3, f7, fl));
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    op = 7'b0110011; funct3 = 3'd0; funct7 = 1'b0; flags = 4'd0;
    #12;
    chk("reset_seen", {31'd0, IllegalSeen}, 32'd0);
    chk("reset_count", BranchCount, 32'd0);
    @(negedge clk); #1; rst_n = 1'b1;

    apply(7'b0110011, 3'd0, 1'b0, 4'h0); settle();
    chk("r_add", {19'd0, act}, {19'd0, 13'b1_0_0_0_00_00_0000_0});
    apply(7'b0110011, 3'd0, 1'b1, 4'h0); settle();
    chk("r_sub", {19'd0, act}, {19'd0, 13'b1_0_0_0_00_00_1000_0});
    apply(7'b0010011, 3'd5, 1'b1, 4'h0); settle();
    chk("i_srai", {19'd0, act}, {19'd0, 13'b1_1_0_0_00_00_1101_0});
    apply(7'b0010011, 3'd0, 1'b1, 4'h0); settle();
    chk("i_addi_f7", {19'd0, act}, {19'd0, 13'b1_1_0_0_00_00_0000_0});
    apply(7'b0000011, 3'd2, 1'b1, 4'hF); settle();
    chk("load", {19'd0, act}, {19'd0, 13'b1_1_0_0_00_01_0000_0});
    apply(7'b0100011, 3'd2, 1'b0, 4'h0); settle();
    chk("store", {19'd0, act}, {19'd0, 13'b0_1_1_0_01_00_0000_0});
    apply(7'b1101111, 3'd0, 1'b0, 4'h0); settle();
    chk("jal", {19'd0, act}, {19'd0, 13'b1_0_0_1_11_10_0000_0});
    apply(7'b0110111, 3'd0, 1'b0, 4'h0); settle();
    chk("lui", {19'd0, act}, {19'd0, 13'b1_0_0_0_10_00_0000_0});

    // branches: {funct3, flags, expected PCSrc}
    begin
      logic [7:0] bv [8];
      bv[0] = {3'd0, 4'b0100, 1'b1};  // beq Z=1
      bv[1] = {3'd1, 4'b0100, 1'b0};  // bne Z=1
      bv[2] = {3'd4, 4'b1000, 1'b1};  // blt N=1 V=0
      bv[3] = {3'd5, 4'b1000, 1'b0};  // bge N=1 V=0
      bv[4] = {3'd6, 4'b0000, 1'b1};  // bltu C=0
      bv[5] = {3'd7, 4'b0000, 1'b0};  // bgeu C=0
      bv[6] = {3'd2, 4'b0100, 1'b0};  // reserved funct3
      bv[7] = {3'd4, 4'b1001, 1'b0};  // blt N=1 V=1
      for (int i = 0; i < 8; i++) begin
        apply(7'b1100011, bv[i][7:5], 1'b0, bv[i][4:1]); settle();
        chk("branch_pcsrc", {31'd0, PCSrc}, {31'd0, bv[i][0]});
      end
    end
    apply(7'b1100011, 3'd0, 1'b1, 4'h0); settle();
    chk("beq_nt", {19'd0, act}, {19'd0, 13'b0_1_1_0_01_00_1000_0});

    // model-only sweep over every branch funct3 and a few flag patterns
    for (int f = 0; f < 8; f++)
      for (int g = 0; g < 16; g += 5)
        apply(7'b1100011, 3'(f), 1'b0, 4'(g));

    chk("seen_before", {31'd0, IllegalSeen}, 32'd0);
    apply(7'b1111111, 3'd3, 1'b1, 4'hF); settle();
    chk("illegal", {19'd0, act}, {19'd0, 13'b0_0_0_0_00_00_0000_1});
    apply(7'b0110011, 3'd0, 1'b0, 4'h0); settle();
    chk("seen_set", {31'd0, IllegalSeen}, 32'd1);
    apply(7'b0110011, 3'd1, 1'b0, 4'h0);
    apply(7'b0000011, 3'd0, 1'b0, 4'h0); settle();
    chk("seen_held", {31'd0, IllegalSeen}, 32'd1);

    // asynchronous reset away from any clock edge
    #1 rst_n = 1'b0;
    #1;
    chk("async_seen", {31'd0, IllegalSeen}, 32'd0);
    chk("async_count", BranchCount, 32'd0);
    chk("async_comb", {19'd0, act}, {19'd0, 13'b1_1_0_0_00_01_0000_0});
    @(negedge clk); #1; rst_n = 1'b1;

    apply(7'b1100011, 3'd0, 1'b0, 4'b0100);  // taken
    apply(7'b0110011, 3'd0, 1'b0, 4'h0);
    apply(7'b1101111, 3'd0, 1'b0, 4'h0);     // taken
    apply(7'b1100011, 3'd1, 1'b0, 4'b0000);  // taken
    apply(7'b0110111, 3'd0, 1'b0, 4'h0);
    settle();
`ifdef RISCY_CONTROL_BRANCH_CNT_EN
    chk("count_three", BranchCount, 32'd3);
`else
    chk("count_tied", BranchCount, 32'd0);
`endif
    chk("seen_after_rst", {31'd0, IllegalSeen}, 32'd0);

    repeat (2) @(negedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
